// File: rtl/display_scan_if.sv
// Signal bundle between the display scan controller and the board side:
// the digit selector, the anodes, the segments and the decimal point.
interface display_scan_if #(
  parameter int ANCHO = 4
);
  logic             en;
  logic             lz_en;
  logic [7:0]       dp_mask;
  logic [ANCHO-1:0] digit_in;
  logic [2:0]       sel;
  logic [7:0]       an;
  logic [6:0]       seg;
  logic             dp;

  modport master (
    input  en,
    input  lz_en,
    input  dp_mask,
    input  digit_in,
    output sel,
    output an,
    output seg,
    output dp
  );

  modport slave (
    output en,
    output lz_en,
    output dp_mask,
    output digit_in,
    input  sel,
    input  an,
    input  seg,
    input  dp
  );
endinterface

// File: rtl/display_scan.sv
// Scan controller for an 8-digit multiplexed 7-segment display: digit select,
// hex decode, anti-ghost blanking and leading-zero suppression.
module display_scan #(
  parameter int ANCHO     = 4,
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  display_scan_if.master bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          seen_q, seen_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          blank_digit;
  logic [3:0]    dig;

  assign dig = bus.digit_in[3:0];

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick        = bus.en && (cnt_q == CNT_LAST);
    // The rightmost digit always shows, so a value of zero still displays "0".
    blank_digit = bus.lz_en && (dig == 4'h0) && !seen_q && (sel_q != 3'd7);

    cnt_d  = cnt_q;
    sel_d  = sel_q;
    seen_d = seen_q;
    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      sel_d = sel_q + 3'd1;
      if (sel_q == 3'd7) begin
        seen_d = 1'b0;
      end else if (dig != 4'h0) begin
        seen_d = 1'b1;
      end
    end

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (bus.en) begin
      // Anodes stay dark for the first cycles of a slot to hide the previous digit.
      an_d  = (cnt_q < CNT_BLANK) ? 8'hFF : ~(8'h80 >> sel_q);
      seg_d = blank_digit ? 7'h7F : hex7(dig);
      dp_d  = ~bus.dp_mask[3'd7 - sel_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= 3'd0;
      seen_q <= 1'b0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      seen_q <= seen_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.sel = sel_q;
  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: randomized and directed stimulus checked against a
// slot/frame arithmetic model of the scan.
module tb_display_scan;

  localparam int P = 4;
  localparam int B = 1;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  display_scan_if #(.ANCHO(4)) bus ();

  display_scan #(
    .ANCHO    (4),
    .PRESCALE (P),
    .BLANK_CYC(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- digit selector model ----------------
  logic [31:0] value;
  logic        ovr_en;
  logic [3:0]  ovr_dig;

  function automatic logic [3:0] pick(input logic [31:0] v, input int s);
    return v[(7 - s) * 4 +: 4];
  endfunction

  function automatic logic [3:0] dig_for(input int s);
    return ovr_en ? ovr_dig : pick(value, s);
  endfunction

  assign bus.digit_in = dig_for(int'(bus.sel));

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // n counts enabled clock edges since reset; slot = n/P, position = n%P.
  logic [18:0] exp_q[$];
  int          n;
  logic [3:0]  last_dig [8];

  always @(negedge clk) begin
    int         ms, pos;
    logic [3:0] d;
    logic       seen;
    logic [7:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic [2:0] esel;
    logic [18:0] e;
    if (rst) begin
      exp_q.delete();
      n = 0;
      for (int i = 0; i < 8; i++) last_dig[i] = 4'h0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sel", 32'(bus.sel), 32'(e[18:16]));
        check("an",  32'(bus.an),  32'(e[15:8]));
        check("seg", 32'(bus.seg), 32'(e[7:1]));
        check("dp",  32'(bus.dp),  32'(e[0]));
      end
      ms  = (n / P) % 8;
      pos = n % P;
      if (bus.en) begin
        d    = dig_for(ms);
        seen = 1'b0;
        for (int s = 0; s < ms; s++) if (last_dig[s] != 4'h0) seen = 1'b1;
        ean  = (pos < B) ? 8'hFF : ~(8'h80 >> ms);
        eseg = (bus.lz_en && d == 4'h0 && !seen && ms != 7) ? 7'h7F : hex_tbl[d];
        edp  = ~bus.dp_mask[7 - ms];
        if (pos == P - 1) last_dig[ms] = d;
        n++;
      end else begin
        ean  = 8'hFF;
        eseg = 7'h7F;
        edp  = 1'b1;
      end
      esel = 3'((n / P) % 8);
      exp_q.push_back({esel, ean, eseg, edp});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, 32'(bus.sel), 32'h0);
    check({tag, "_an"},  32'(bus.an),  32'hFF);
    check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    check({tag, "_dp"},  32'(bus.dp),  32'h1);
  endtask

  task automatic rand_value();
    for (int i = 0; i < 8; i++)
      value[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.lz_en   = 1'b0;
    bus.dp_mask = 8'h00;
    value       = 32'h0;
    ovr_en      = 1'b0;
    ovr_dig     = 4'h0;
    #2;
    check_reset_outputs("por");
    cyc(3);
    rst = 1'b0;

    // idle with scan disabled
    cyc(20);

    // scan timing, digits 1..8
    value  = 32'h12345678;
    bus.en = 1'b1;
    cyc(64);

    // asynchronous reset mid-scan
    cyc(10);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    cyc(3);
    rst = 1'b0;
    cyc(20);

    // enable pause at cnt=2, sel=3, then resume
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    bus.en = 1'b1;
    cyc(3 * P + 2);
    bus.en = 1'b0;
    cyc(10);
    bus.en = 1'b1;
    cyc(40);

    // hex decode of every digit value
    ovr_en = 1'b1;
    for (int d = 0; d < 16; d++) begin
      ovr_dig = 4'(d);
      cyc(1);
    end
    ovr_en = 1'b0;

    // leading-zero suppression and decimal point
    value       = 32'h00000305;
    bus.lz_en   = 1'b1;
    bus.dp_mask = 8'b0000_0100;
    cyc(96);
    value = 32'h0;
    cyc(64);
    value = 32'h00000305;
    cyc(64);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) bus.lz_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) bus.dp_mask = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) rand_value();
      ovr_en  = ($urandom_range(0, 7) == 0);
      ovr_dig = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cyc(1);
    end
    ovr_en = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
